// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared constants and types for the AXI interconnect arbiters
package axi_ic_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/axi_arb_rr_pick.sv
// rtl/axi_arb_rr_pick.sv - combinational rotating-priority picker (req, ptr) -> (found, idx)
module axi_arb_rr_pick #(
  parameter int NUM_MST = 3,
  parameter int IDX_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_MST-1:0] req2;
  logic [2*NUM_MST-1:0] mask;

  // Lower copy masked below ptr; the unmasked upper copy supplies the wrap-around.
  always_comb begin
    req2  = {req, req};
    mask  = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < 2*NUM_MST; j++) begin
      mask[j] = req2[j] && (j >= int'(ptr));
    end
    for (int j = 2*NUM_MST-1; j >= 0; j--) begin
      if (mask[j]) begin
        found = 1'b1;
        idx   = IDX_W'((j >= NUM_MST) ? (j - NUM_MST) : j);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter_rr.sv
// rtl/axi_wr_arbiter_rr.sv - N-master write-channel arbiter, RR or fixed priority, with hold watchdog
module axi_wr_arbiter_rr
  import axi_ic_pkg::*;
#(
  parameter int NUM_MST  = 3,
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_HOLD = 0,
  localparam int IDX_W   = $clog2(NUM_MST)
) (
  input  logic               sys_clk,
  input  logic               sys_rstn,
  input  logic [NUM_MST-1:0] wr_req,
  input  logic               wr_done,
  output logic [NUM_MST-1:0] wr_grant,
  output logic [IDX_W-1:0]   wr_grant_id,
  output logic               wr_grant_vld,
  output logic               hold_timeout
);

  localparam logic [IDX_W-1:0] LAST_ID   = IDX_W'(NUM_MST - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(MAX_HOLD - 1);

  arb_state_e         state, state_nxt;
  logic [NUM_MST-1:0] grant_nxt;
  logic [IDX_W-1:0]   id_nxt, prio_ptr, ptr_nxt, pick_ptr, pick_idx;
  logic               pick_found;
  logic [15:0]        hold_cnt, cnt_nxt;
  logic               timeout_nxt, timeout_hit;

  assign pick_ptr     = (ARB_MODE == ARB_FIXED) ? '0 : prio_ptr;
  assign timeout_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign wr_grant_vld = |wr_grant;

  axi_arb_rr_pick #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (wr_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt   = state;
    grant_nxt   = wr_grant;
    id_nxt      = wr_grant_id;
    ptr_nxt     = prio_ptr;
    cnt_nxt     = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt = ARB_BUSY;
          grant_nxt = NUM_MST'(1) << pick_idx;
          id_nxt    = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ARB_BUSY: begin
        cnt_nxt = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
        if (wr_done || timeout_hit) begin
          state_nxt   = ARB_IDLE;
          grant_nxt   = '0;
          id_nxt      = '0;
          // wr_done on the watchdog cycle counts as a normal completion
          timeout_nxt = !wr_done;
          if (ARB_MODE != ARB_FIXED) begin
            ptr_nxt = (wr_grant_id == LAST_ID) ? '0 : wr_grant_id + IDX_W'(1);
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state        <= ARB_IDLE;
      wr_grant     <= '0;
      wr_grant_id  <= '0;
      prio_ptr     <= '0;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_grant     <= grant_nxt;
      wr_grant_id  <= id_nxt;
      prio_ptr     <= ptr_nxt;
      hold_cnt     <= cnt_nxt;
      hold_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// tb/tb_axi_wr_arbiter_rr.sv - self-checking bench for axi_wr_arbiter_rr (RR+watchdog and fixed-priority instances)
module tb_axi_wr_arbiter_rr;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] req3, g3;
  logic [1:0] id3;
  logic       done3, v3, to3;
  logic [4:0] req5, g5;
  logic [2:0] id5;
  logic       done5, v5, to5;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] grant;
    logic [3:0] id;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] req;
    logic [2:0] busy_req;
    int         busy;
    bit         use_done;
    logic [1:0] exp_id;
    bit         exp_to;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  axi_wr_arbiter_rr #(.NUM_MST(3), .ARB_MODE(0), .MAX_HOLD(8)) u_rr (
    .sys_clk(clk), .sys_rstn(rstn), .wr_req(req3), .wr_done(done3),
    .wr_grant(g3), .wr_grant_id(id3), .wr_grant_vld(v3), .hold_timeout(to3)
  );

  axi_wr_arbiter_rr #(.NUM_MST(5), .ARB_MODE(1), .MAX_HOLD(0)) u_fx (
    .sys_clk(clk), .sys_rstn(rstn), .wr_req(req5), .wr_done(done5),
    .wr_grant(g5), .wr_grant_id(id5), .wr_grant_vld(v5), .hold_timeout(to5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot_rr", 32'($onehot0(g3)), 1);
    chk("vld_rr", 32'(v3), 32'(|g3));
    chk("onehot_fx", 32'($onehot0(g5)), 1);
    chk("vld_fx", 32'(v5), 32'(|g5));
    if (v3) chk("id_rr", 32'(g3), 32'(1) << id3);
    if (v5) chk("id_fx", 32'(g5), 32'(1) << id5);
  end

  task automatic wait_vld3(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!v3 && lat < 10);
  endtask

  task automatic wait_vld5(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!v5 && lat < 10);
  endtask

  task automatic pop_exp(output exp_t e);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: got 0 entries expected >=1");
      e = '{grant: '0, id: '0};
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req3 = '0; done3 = 1'b0; req5 = '0; done5 = 1'b0;
    @(negedge clk);
    chk("rst_grant_rr", 32'(g3), 0);
    chk("rst_id_rr", 32'(id3), 0);
    chk("rst_vld_rr", 32'(v3), 0);
    chk("rst_to_rr", 32'(to3), 0);
    chk("rst_grant_fx", 32'(g5), 0);
    chk("rst_id_fx", 32'(id5), 0);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    bit   locked;
    exp_t e;
    logic [1:0] seq_ids[4];

    tbl[0]  = '{3'b111, 3'b111, 2, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{3'b111, 3'b001, 4, 1'b1, 2'd1, 1'b0};
    tbl[2]  = '{3'b011, 3'b011, 2, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{3'b011, 3'b000, 3, 1'b1, 2'd1, 1'b0};
    tbl[4]  = '{3'b100, 3'b100, 1, 1'b1, 2'd2, 1'b0};
    tbl[5]  = '{3'b001, 3'b001, 8, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{3'b111, 3'b111, 2, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{3'b100, 3'b100, 8, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{3'b110, 3'b110, 1, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{3'b111, 3'b111, 5, 1'b1, 2'd2, 1'b0};
    tbl[10] = '{3'b111, 3'b111, 1, 1'b1, 2'd0, 1'b0};

    rstn = 1'b0;
    req3 = '0; done3 = 1'b0; req5 = '0; done5 = 1'b0;
    do_reset();

    // Empty request and stray wr_done in IDLE leave the arbiter idle.
    @(negedge clk);
    done3 = 1'b1;
    @(negedge clk);
    done3 = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(g3), 0);
    chk("idle_no_to", 32'(to3), 0);

    // All masters requesting: order 0,1,2,0 with one idle cycle between grants.
    seq_ids = '{2'd0, 2'd1, 2'd2, 2'd0};
    foreach (seq_ids[k]) sb.push_back('{grant: 5'(3'b001 << seq_ids[k]), id: 4'(seq_ids[k])});
    req3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_vld3(lat);
      chk("seq_lat", 32'(lat), 1);
      pop_exp(e);
      chk("seq_grant", 32'(g3), 32'(e.grant));
      chk("seq_id", 32'(id3), 32'(e.id));
      done3 = 1'b1;
      @(negedge clk);
      done3 = 1'b0;
      chk("seq_gap", 32'(g3), 0);
      if (k == 3) req3 = '0;
    end

    do_reset();

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      req3 = tbl[i].req;
      sb.push_back('{grant: 5'(3'b001 << tbl[i].exp_id), id: 4'(tbl[i].exp_id)});
      wait_vld3(lat);
      chk("tbl_lat", 32'(lat), 1);
      pop_exp(e);
      chk("tbl_grant", 32'(g3), 32'(e.grant));
      chk("tbl_id", 32'(id3), 32'(e.id));
      req3 = tbl[i].busy_req;
      locked = 1'b1;
      for (int c = 1; c < tbl[i].busy; c++) begin
        @(negedge clk);
        if (g3 !== e.grant[2:0]) locked = 1'b0;
      end
      chk("tbl_lock", 32'(locked), 1);
      done3 = tbl[i].use_done;
      @(negedge clk);
      done3 = 1'b0;
      req3 = '0;
      chk("tbl_release", 32'(g3), 0);
      chk("tbl_timeout", 32'(to3), 32'(tbl[i].exp_to));
      @(negedge clk);
      chk("tbl_pulse_end", 32'(to3), 0);
      chk("tbl_idle", 32'(g3), 0);
    end

    // Reset asserted mid-grant clears outputs before the next clock edge.
    @(negedge clk);
    req3 = 3'b010;
    wait_vld3(lat);
    chk("rstmid_grant", 32'(g3), 32'(3'b010));
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_async_grant", 32'(g3), 0);
    chk("rstmid_async_vld", 32'(v3), 0);
    chk("rstmid_async_id", 32'(id3), 0);
    @(negedge clk);
    rstn = 1'b1;
    req3 = 3'b111;
    wait_vld3(lat);
    chk("post_rst_first", 32'(g3), 32'(3'b001));
    done3 = 1'b1;
    @(negedge clk);
    done3 = 1'b0;
    req3 = '0;

    // Fixed priority: lowest asserted index wins every round.
    for (int r = 0; r < 6; r++) begin
      logic [4:0] rq;
      logic [2:0] xi;
      case (r)
        3:       begin rq = 5'b10000; xi = 3'd4; end
        4:       begin rq = 5'b11000; xi = 3'd3; end
        5:       begin rq = 5'b11111; xi = 3'd0; end
        default: begin rq = 5'b10110; xi = 3'd1; end
      endcase
      @(negedge clk);
      req5 = rq;
      sb.push_back('{grant: 5'b00001 << xi, id: 4'(xi)});
      wait_vld5(lat);
      chk("fx_lat", 32'(lat), 1);
      pop_exp(e);
      chk("fx_grant", 32'(g5), 32'(e.grant));
      chk("fx_id", 32'(id5), 32'(e.id));
      done5 = 1'b1;
      @(negedge clk);
      done5 = 1'b0;
      req5 = '0;
      chk("fx_release", 32'(g5), 0);
      chk("fx_no_to", 32'(to5), 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
